// File: rtl/osd_timestamp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// osd_timestamp_pkg : command and FSM encodings for the timestamp controller
// Rev 1.0
// ----------------------------------------------------------------------
package osd_timestamp_pkg;

  typedef enum logic [1:0] {
    TS_NOP   = 2'd0,
    TS_START = 2'd1,
    TS_STOP  = 2'd2,
    TS_CLEAR = 2'd3
  } ts_cmd_e;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_CLEARING = 2'd2
  } ts_state_e;

  // ID width for n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/osd_timestamp.sv
`default_nettype none
// ----------------------------------------------------------------------
// osd_timestamp : free-running timestamp counter with enable and wrap pulse
// Rev 1.0
// ----------------------------------------------------------------------
module osd_timestamp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= enable && (count == {WIDTH{1'b1}});
      if (enable) begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/osd_timestamp_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// osd_timestamp_ctrl : timestamp sequencing, prescaler and round-robin snapshots
// Rev 1.0
// ----------------------------------------------------------------------
module osd_timestamp_ctrl
  import osd_timestamp_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int NREQ       = 4,
  parameter  int PRESCALE_W = 8,
  localparam int IDW        = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [PRESCALE_W-1:0] cmd_prescale,
  output logic                  running,
  output logic [WIDTH-1:0]      timestamp,
  output logic                  wrap,
  input  logic [NREQ-1:0]       snap_req,
  output logic [NREQ-1:0]       snap_grant,
  output logic                  snap_valid,
  input  logic                  snap_ready,
  output logic [IDW-1:0]        snap_id,
  output logic [WIDTH-1:0]      snap_ts
);

  ts_state_e             state;
  ts_state_e             state_nxt;
  ts_cmd_e               op;
  logic                  cmd_fire;
  logic                  saved_run;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [PRESCALE_W-1:0] prescale_cnt;
  logic                  tick;
  logic                  ctr_rst;

  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_found;
  logic                  slot_free;

  assign op      = ts_cmd_e'(cmd_op);
  assign tick    = (state == ST_RUNNING) && (prescale_cnt == prescale_reg);
  assign running = (state == ST_RUNNING) || ((state == ST_CLEARING) && saved_run);
  assign ctr_rst = rst || (state == ST_CLEARING);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STOPPED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = (state != ST_CLEARING);
    cmd_fire  = cmd_valid && cmd_ready;
    case (state)
      ST_STOPPED, ST_RUNNING: begin
        if (cmd_fire) begin
          case (op)
            TS_START: state_nxt = ST_RUNNING;
            TS_STOP:  state_nxt = ST_STOPPED;
            TS_CLEAR: state_nxt = ST_CLEARING;
            default:  state_nxt = state;
          endcase
        end
      end
      ST_CLEARING: state_nxt = saved_run ? ST_RUNNING : ST_STOPPED;
      default:     state_nxt = ST_STOPPED;
    endcase
  end

  // A START always restarts the prescale period, even when already running.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_reg <= '0;
      prescale_cnt <= '0;
      saved_run    <= 1'b0;
    end else begin
      if (cmd_fire && (op == TS_START)) begin
        prescale_reg <= cmd_prescale;
        prescale_cnt <= '0;
      end else if (state == ST_CLEARING) begin
        prescale_cnt <= '0;
      end else if (state == ST_RUNNING) begin
        prescale_cnt <= tick ? '0 : prescale_cnt + PRESCALE_W'(1);
      end
      if (cmd_fire && (op == TS_CLEAR)) begin
        saved_run <= (state == ST_RUNNING);
      end
    end
  end

  osd_timestamp #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk    (clk),
    .rst    (ctr_rst),
    .enable (tick),
    .count  (timestamp),
    .wrap   (wrap)
  );

  assign slot_free = !snap_valid || snap_ready;

  // Search order starts one past the last winner; k is the outer loop so the
  // first hit in rotated order wins.
  always_comb begin
    snap_grant = '0;
    gnt_idx    = '0;
    gnt_found  = 1'b0;
    if (slot_free) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int j = 0; j < NREQ; j++) begin
          if (!gnt_found && snap_req[j] && (((int'(rr_ptr) + 1 + k) % NREQ) == j)) begin
            gnt_found     = 1'b1;
            snap_grant[j] = 1'b1;
            gnt_idx       = IDW'(j);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_valid <= 1'b0;
      snap_id    <= '0;
      snap_ts    <= '0;
      rr_ptr     <= IDW'(NREQ - 1);
    end else if (gnt_found) begin
      snap_valid <= 1'b1;
      snap_id    <= gnt_idx;
      snap_ts    <= timestamp;
      rr_ptr     <= gnt_idx;
    end else if (snap_ready) begin
      snap_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_osd_timestamp_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_osd_timestamp_ctrl : scenario tasks plus snapshot scoreboard
// Rev 1.0
// ----------------------------------------------------------------------
module tb_osd_timestamp_ctrl;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int PW    = 8;
  localparam int IDW   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [PW-1:0]    cmd_prescale = '0;
  logic             running;
  logic [WIDTH-1:0] timestamp;
  logic             wrap;
  logic [NREQ-1:0]  snap_req = '0;
  logic [NREQ-1:0]  snap_grant;
  logic             snap_valid;
  logic             snap_ready = 1'b1;
  logic [IDW-1:0]   snap_id;
  logic [WIDTH-1:0] snap_ts;

  int checks = 0;
  int errors = 0;
  int exp_ts = 0;
  logic [IDW+WIDTH-1:0] exp_q[$];

  osd_timestamp_ctrl #(
    .WIDTH      (WIDTH),
    .NREQ       (NREQ),
    .PRESCALE_W (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_prescale (cmd_prescale),
    .running      (running),
    .timestamp    (timestamp),
    .wrap         (wrap),
    .snap_req     (snap_req),
    .snap_grant   (snap_grant),
    .snap_valid   (snap_valid),
    .snap_ready   (snap_ready),
    .snap_id      (snap_id),
    .snap_ts      (snap_ts)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [IDW+WIDTH-1:0] e;
    if (!rst && snap_valid && snap_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got id=%0d ts=%0d, nothing expected", snap_id, snap_ts);
      end else begin
        e = exp_q.pop_front();
        if ({snap_id, snap_ts} !== e) begin
          errors++;
          $display("FAIL sb_snapshot: got id=%0d ts=%0d, expected id=%0d ts=%0d",
                   snap_id, snap_ts, e[IDW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic tnext();
    next();
    exp_ts = (exp_ts + 1) % 16;
  endtask

  task automatic issue(input logic [1:0] op, input logic [PW-1:0] p);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_prescale = p;
    next();
    cmd_valid    = 1'b0;
    cmd_op       = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next();
    next();
    checks++;
    if ({running, wrap, snap_valid, snap_grant} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got run=%0b wrap=%0b sv=%0b gnt=%b, expected all 0",
               running, wrap, snap_valid, snap_grant);
    end
    checks++;
    if (timestamp !== 4'd0 || snap_ts !== 4'd0 || snap_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: got ts=%0d snap_ts=%0d snap_id=%0d, expected 0",
               timestamp, snap_ts, snap_id);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %0b, expected 1", cmd_ready);
    end
    rst = 1'b0;
    next();
  endtask

  task automatic test_run_p0();
    issue(2'd1, 8'd0);
    checks++;
    if (running !== 1'b1 || timestamp !== 4'd0) begin
      errors++;
      $display("FAIL p0_start: got run=%0b ts=%0d, expected run=1 ts=0", running, timestamp);
    end
    for (int k = 1; k <= 5; k++) begin
      next();
      checks++;
      if (timestamp !== 4'(k)) begin
        errors++;
        $display("FAIL p0_count: got ts=%0d, expected %0d", timestamp, k);
      end
    end
    issue(2'd2, 8'd0);
    checks++;
    if (timestamp !== 4'd6 || running !== 1'b0) begin
      errors++;
      $display("FAIL p0_stop: got ts=%0d run=%0b, expected ts=6 run=0", timestamp, running);
    end
    next();
    checks++;
    if (timestamp !== 4'd6) begin
      errors++;
      $display("FAIL p0_hold: got ts=%0d, expected 6", timestamp);
    end
  endtask

  task automatic test_prescale();
    issue(2'd3, 8'd0);
    checks++;
    if (cmd_ready !== 1'b0 || timestamp !== 4'd6 || running !== 1'b0) begin
      errors++;
      $display("FAIL clr_stopped: got rdy=%0b ts=%0d run=%0b, expected rdy=0 ts=6 run=0",
               cmd_ready, timestamp, running);
    end
    next();
    checks++;
    if (timestamp !== 4'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_done: got ts=%0d rdy=%0b, expected ts=0 rdy=1", timestamp, cmd_ready);
    end
    issue(2'd1, 8'd3);
    for (int k = 1; k <= 8; k++) begin
      next();
      checks++;
      if (timestamp !== 4'(k / 4)) begin
        errors++;
        $display("FAIL p3_count: edge %0d got ts=%0d, expected %0d", k, timestamp, k / 4);
      end
    end
    issue(2'd1, 8'd1);
    checks++;
    if (timestamp !== 4'd2 || running !== 1'b1) begin
      errors++;
      $display("FAIL p1_restart: got ts=%0d run=%0b, expected ts=2 run=1", timestamp, running);
    end
    for (int k = 1; k <= 6; k++) begin
      next();
      checks++;
      if (timestamp !== 4'(2 + k / 2)) begin
        errors++;
        $display("FAIL p1_count: edge %0d got ts=%0d, expected %0d", k, timestamp, 2 + k / 2);
      end
    end
    issue(2'd2, 8'd0);
    checks++;
    if (timestamp !== 4'd5 || running !== 1'b0) begin
      errors++;
      $display("FAIL p1_stop: got ts=%0d run=%0b, expected ts=5 run=0", timestamp, running);
    end
  endtask

  task automatic test_wrap();
    issue(2'd3, 8'd0);
    next();
    checks++;
    if (timestamp !== 4'd0) begin
      errors++;
      $display("FAIL wrap_clear: got ts=%0d, expected 0", timestamp);
    end
    issue(2'd1, 8'd0);
    exp_ts = 0;
    for (int k = 1; k <= 17; k++) begin
      tnext();
      checks++;
      if (timestamp !== 4'(exp_ts) || wrap !== (k == 16)) begin
        errors++;
        $display("FAIL wrap_seq: edge %0d got ts=%0d wrap=%0b, expected ts=%0d wrap=%0b",
                 k, timestamp, wrap, exp_ts, (k == 16));
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_ready = 1'b1;
    snap_req   = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (snap_grant !== 4'(1 << (i % 4))) begin
        errors++;
        $display("FAIL b2b_grant: step %0d got %b, expected %b", i, snap_grant, 4'(1 << (i % 4)));
      end
      exp_q.push_back({IDW'(i % 4), WIDTH'(exp_ts)});
      tnext();
    end
    snap_req = '0;
    checks++;
    if (snap_valid !== 1'b1 || snap_id !== 2'd0) begin
      errors++;
      $display("FAIL b2b_last: got valid=%0b id=%0d, expected valid=1 id=0", snap_valid, snap_id);
    end
    tnext();
  endtask

  task automatic test_backpressure();
    int g_ts;
    snap_ready = 1'b0;
    snap_req   = 4'b0001;
    #1;
    checks++;
    if (snap_grant !== 4'b0001) begin
      errors++;
      $display("FAIL bp_first: got %b, expected 0001", snap_grant);
    end
    g_ts = exp_ts;
    exp_q.push_back({2'd0, WIDTH'(exp_ts)});
    tnext();
    snap_req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (snap_grant !== 4'b0000 || snap_valid !== 1'b1 || snap_id !== 2'd0 || snap_ts !== 4'(g_ts)) begin
        errors++;
        $display("FAIL bp_stall: got gnt=%b v=%0b id=%0d ts=%0d, expected gnt=0000 v=1 id=0 ts=%0d",
                 snap_grant, snap_valid, snap_id, snap_ts, g_ts);
      end
      tnext();
    end
    snap_ready = 1'b1;
    #1;
    checks++;
    if (snap_grant !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release: got %b, expected 0100", snap_grant);
    end
    exp_q.push_back({2'd2, WIDTH'(exp_ts)});
    tnext();
    snap_req = '0;
    tnext();
  endtask

  task automatic test_clear_snap();
    for (int k = 0; k < 20 && exp_ts != 9; k++) begin
      tnext();
    end
    checks++;
    if (timestamp !== 4'd9) begin
      errors++;
      $display("FAIL cs_reach9: got ts=%0d, expected 9", timestamp);
    end
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    snap_req  = 4'b0010;
    #1;
    checks++;
    if (snap_grant !== 4'b0010 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cs_grant: got gnt=%b rdy=%0b, expected gnt=0010 rdy=1", snap_grant, cmd_ready);
    end
    exp_q.push_back({2'd1, 4'd9});
    next();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    snap_req  = '0;
    checks++;
    if (cmd_ready !== 1'b0 || running !== 1'b1 || timestamp !== 4'd10) begin
      errors++;
      $display("FAIL cs_clearing: got rdy=%0b run=%0b ts=%0d, expected rdy=0 run=1 ts=10",
               cmd_ready, running, timestamp);
    end
    next();
    checks++;
    if (timestamp !== 4'd0 || running !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cs_cleared: got ts=%0d run=%0b rdy=%0b, expected ts=0 run=1 rdy=1",
               timestamp, running, cmd_ready);
    end
    exp_ts = 0;
    for (int k = 0; k < 2; k++) begin
      tnext();
      checks++;
      if (timestamp !== 4'(exp_ts)) begin
        errors++;
        $display("FAIL cs_resume: got ts=%0d, expected %0d", timestamp, exp_ts);
      end
    end
  endtask

  task automatic test_reset_drop();
    snap_ready = 1'b0;
    snap_req   = 4'b0001;
    next();
    snap_req = '0;
    checks++;
    if (snap_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_pending: got valid=%0b, expected 1", snap_valid);
    end
    rst = 1'b1;
    next();
    checks++;
    if (snap_valid !== 1'b0 || running !== 1'b0 || timestamp !== 4'd0) begin
      errors++;
      $display("FAIL rd_reset: got valid=%0b run=%0b ts=%0d, expected 0 0 0",
               snap_valid, running, timestamp);
    end
    rst        = 1'b0;
    snap_ready = 1'b1;
    next();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_run_p0();
    test_prescale();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_clear_snap();
    test_reset_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
